// File: rtl/ram_pkg.sv
// Shared types and helpers for the tap RAM family of blocks.
package ram_pkg;

    typedef enum logic { SER_IDLE, SER_SEND } ser_state_e;

    // Number of taps in a vector of 2**addr_w words.
    function automatic int vec_len(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/tap_serializer.sv
// Parallel-to-serial unloader: captures a full tap vector in one handshake
// and streams it out one word per cycle, tap 0 first.
module tap_serializer
    import ram_pkg::*;
#(
    parameter int DATA_ = 8,
    parameter int ADDR_ = 8
) (
    input  logic                             clk,
    input  logic                             aclr_n,
    input  logic                             cke,
    input  logic [2**ADDR_-1:0][DATA_-1:0]   taps,
    input  logic                             load_valid,
    output logic                             load_ready,
    output logic [DATA_-1:0]                 dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             dout_last,
    output logic [ADDR_-1:0]                 dout_index
);

    localparam int N = vec_len(ADDR_);

    ser_state_e                state, state_nx;
    logic [ADDR_-1:0]          idx;
    logic [N-1:0][DATA_-1:0]   vec_q;
    logic                      at_last;
    logic                      load_xfer;
    logic                      out_xfer;

    assign at_last    = &idx;
    assign dout_valid = (state == SER_SEND);
    assign dout_last  = dout_valid & at_last;
    assign dout       = vec_q[idx];
    assign dout_index = idx;

    // A reload is only taken alongside the final word so vectors abut with no bubble.
    assign load_ready = aclr_n & cke & ((state == SER_IDLE) | (dout_last & dout_ready));
    assign load_xfer  = load_valid & load_ready;
    assign out_xfer   = dout_valid & dout_ready & cke;

    always_comb begin
        state_nx = state;
        case (state)
            SER_IDLE: if (load_xfer) state_nx = SER_SEND;
            SER_SEND: if (out_xfer && at_last && !load_xfer) state_nx = SER_IDLE;
            default:  state_nx = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)  state <= SER_IDLE;
        else if (cke) state <= state_nx;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            idx   <= '0;
            vec_q <= '0;
        end else if (load_xfer) begin
            idx   <= '0;
            vec_q <= taps;
        end else if (out_xfer && !at_last) begin
            idx   <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_tap_serializer.sv
// Randomized and directed check of tap_serializer against a queue-based model.
module tb_tap_serializer;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int N  = 4;

    logic                    clk = 1'b0;
    logic                    aclr_n = 1'b0;
    logic                    cke = 1'b0;
    logic [N-1:0][DW-1:0]    taps = '0;
    logic                    load_valid = 1'b0;
    logic                    load_ready;
    logic [DW-1:0]           dout;
    logic                    dout_valid;
    logic                    dout_ready = 1'b0;
    logic                    dout_last;
    logic [AW-1:0]           dout_index;

    int errs   = 0;
    int checks = 0;

    // Words still owed to the output, oldest first.
    logic [DW-1:0] q[$];

    tap_serializer #(.DATA_(DW), .ADDR_(AW)) dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .cke        (cke),
        .taps       (taps),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .dout_index (dout_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // Inputs are already driven; check outputs late in the cycle, advance the model, cross the edge.
    task automatic step();
        logic exp_lr;
        int   sz;
        #3;
        if (!aclr_n) q.delete();
        sz     = q.size();
        exp_lr = aclr_n && cke && (sz == 0 || (sz == 1 && dout_ready));
        chk("load_ready", 32'(load_ready), 32'(exp_lr));
        chk("dout_valid", 32'(dout_valid), 32'(sz != 0));
        chk("dout_last",  32'(dout_last),  32'(sz == 1));
        if (sz != 0) begin
            chk("dout",       32'(dout),       32'(q[0]));
            chk("dout_index", 32'(dout_index), 32'(N - sz));
        end else if (!aclr_n) begin
            chk("dout_rst",  32'(dout),       32'd0);
            chk("index_rst", 32'(dout_index), 32'd0);
        end
        if (aclr_n && cke) begin
            if (sz != 0 && dout_ready) q.delete(0);
            if (load_valid && exp_lr)
                for (int i = 0; i < N; i++) q.push_back(taps[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_taps(input logic [DW-1:0] base, input logic [DW-1:0] inc);
        for (int i = 0; i < N; i++) taps[i] = base + DW'(i) * inc;
    endtask

    initial begin
        logic dr_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        @(posedge clk);
        #1;

        // Reset with random inputs, then release.
        cke = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'($urandom);
            dout_ready = 1'($urandom);
            taps       = $urandom();
            step();
        end
        aclr_n = 1'b1; load_valid = 1'b0; dout_ready = 1'b1;
        step();

        // Basic serialization.
        set_taps(8'h11, 8'h11);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (5) step();

        // Backpressure.
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            dout_ready = dr_pat[i];
            step();
        end
        dout_ready = 1'b1;
        repeat (3) step();

        // Back-to-back, with mid-vector tap changes ignored.
        set_taps(8'h11, 8'h11);
        load_valid = 1'b1;
        step();
        step();
        taps = $urandom(); step();
        taps = $urandom(); step();
        set_taps(8'hA0, 8'h01);
        step();
        load_valid = 1'b0;
        repeat (5) step();

        // Clock enable stall on word 1.
        set_taps(8'h11, 8'h11);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step();
        cke = 1'b0;
        repeat (3) step();
        cke = 1'b1;
        repeat (4) step();

        // Reset while word 2 is presented.
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (2) step();
        aclr_n = 1'b0;
        step();
        aclr_n = 1'b1;
        set_taps(8'h51, 8'h01);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (5) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(0, 1) == 0);
            dout_ready = ($urandom_range(0, 9) < 7);
            cke        = ($urandom_range(0, 19) != 0);
            aclr_n     = ($urandom_range(0, 99) != 0);
            taps       = $urandom();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tap_serializer.md
# tap_serializer

Parallel-to-serial unloader for tap vectors: accepts one full vector of 2**ADDR_ words in a single handshake and emits the words one per cycle on a valid/ready stream, in ascending tap index. It is the reverse of the block-RAM shift register with taps. A window of taps produced or modified downstream is turned back into a serial word stream for the next stage or for write-back.

## Interface
Parameters:
- DATA_, 8, word width in bits
- ADDR_, 8, log2 of vector length N = 2**ADDR_; ADDR_ ≥ 1 is required

Ports:
- clk  in  1  clock; all state changes on the rising edge
- aclr_n  in  1  reset, asynchronous, active-low
- cke  in  1  clock enable; low freezes all state
- taps  in  [2**ADDR_-1:0][DATA_-1:0]  vector to serialize; taps[0] is emitted first
- load_valid  in  1  taps is valid
- load_ready  out  1  the block accepts a vector this cycle
- dout  out  DATA_  current word
- dout_valid  out  1  dout is valid
- dout_ready  in  1  downstream accepts dout
- dout_last  out  1  dout is word N-1 of the current vector
- dout_index  out  ADDR_  tap index of the current dout

## Operation
- State machine with two states, SER_IDLE and SER_SEND.
- Load transfer: load_valid & load_ready (load_ready already includes cke).
- Output transfer: dout_valid & dout_ready & cke.
- **SER_IDLE:**
  - load_ready = cke.
  - On a load transfer: all N words are captured into a register buffer, index is set to 0, and the state moves to SER_SEND.
- **SER_SEND:**
  - dout_valid = 1, dout = buf[index], dout_index = index, dout_last = (index == N-1).
  - On an output transfer with index < N-1: index increments.
  - On an output transfer with index == N-1: the state returns to SER_IDLE, unless a load transfer happens in the same cycle.
- **Back-to-back:** in SER_SEND, load_ready = cke & dout_last & dout_ready.
  - A load transfer in the same cycle as the final output transfer reloads the buffer, sets index to 0 and stays in SER_SEND.
  - There is no bubble between vectors.
- taps and load_valid are ignored in all other SER_SEND cycles.
- dout, dout_index and dout_last are held stable while dout_valid = 1 and no output transfer occurs.
- **cke = 0:**
  - No register updates.
  - load_ready = 0.
  - dout_valid and dout are held.
  - dout_ready is not counted.
- **aclr_n low** (asynchronous, including mid-vector):
  - State returns to SER_IDLE.
  - index = 0, buffer = 0, dout = 0, dout_valid = 0, dout_last = 0, dout_index = 0.
  - load_ready = 0 while aclr_n is low.
  - The vector in flight is discarded.

## Timing
- Load accepted at edge t: word 0 is valid in cycle t+1.
- With dout_ready held high, word k is presented in cycle t+1+k, and dout_last is asserted in cycle t+N.
- Sustained throughput: one word per cycle, N cycles per vector, including back-to-back loads.
- load_ready has a combinational path from dout_ready (SER_SEND only). All other outputs are registered or decoded from registers.
- First load is possible in the first enabled cycle after aclr_n deasserts.

## Structure
- The shared package ram_pkg holds:
  - typedef enum logic { SER_IDLE, SER_SEND } ser_state_e
  - the vector length constant expression
- Single module, no sub-module.
- The buffer is a plain register array, because a single-cycle parallel load of N words cannot use block RAM.
- The index counter is an ADDR_-bit register.

## Test plan
All scenarios use DATA_=8 and ADDR_=2 (N=4).
1. **Reset:** aclr_n low for 3 cycles with random inputs, then release with cke=1 -> during reset dout_valid=0, dout=0x00, dout_last=0, load_ready=0; after release load_ready=1.
2. **Basic serialization:** taps[0..3] = 0x11, 0x22, 0x33, 0x44 loaded at t, dout_ready=1 -> dout 0x11/0x22/0x33/0x44 in cycles t+1..t+4, dout_index 0..3, dout_last only with 0x44, then load_ready=1.
3. **Backpressure:** dout_ready pattern 1,0,0,1,0,1,1 -> each word held until accepted, no word lost or duplicated, index advances only on transfer.
4. **Back-to-back:** second vector 0xA0..0xA3 offered with load_valid during the 0x44 transfer -> 0xA0 appears the next cycle, no idle cycle; taps changed mid-vector have no effect.
5. **Clock enable:** cke=0 for 3 cycles while 0x22 is presented and dout_ready=1 -> dout stays 0x22, index stays 1, load_ready=0; resumes with 0x33 after cke returns.
6. **Reset mid-vector:** aclr_n pulsed low while word 2 is presented -> dout_valid=0 immediately; a new load afterwards starts again from taps[0].
